// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the execute/memory units, the issue stage and the
// register file. The arbiter is the slave; units, issue and the register
// file together form the master side.
interface rf_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 5,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsv_valid;
    logic [AW-1:0]         rsv_addr;
    logic [2**AW-1:0]      pending;
    logic                  reg_wr;
    logic [AW-1:0]         waddr;
    logic [DW-1:0]         wdata;

    modport master (
        output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
        input  req_ready, pending, reg_wr, waddr, wdata
    );

    modport slave (
        input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
        output req_ready, pending, reg_wr, waddr, wdata
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// plus the pending-write scoreboard used by hazard detection.
// Writes to x0 are accepted and consumed but never reach the register file.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 5,
    parameter int DW      = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    rf_wb_arbiter_if.slave  bus
);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG = 2**AW;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic               reg_wr_q, reg_wr_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [NREG-1:0]    pending_q, pending_d;

    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               grant_vld;

    logic [AW-1:0]      addr_arr [NUM_REQ];
    logic [DW-1:0]      data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
        assign data_arr[gi] = bus.req_data[gi*DW +: DW];
    end

    // Round-robin pick: first valid requester at or above ptr, wrapping.
    always_comb begin
        logic [PW:0] sum;
        sum       = '0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            if (!grant_vld && bus.req_valid[sum[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = sum[PW-1:0];
            end
        end
        // Nothing is granted while reset is held.
        if (rst_i) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Next write-port contents and pointer from the accepted request.
    always_comb begin
        ptr_d    = ptr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        reg_wr_d = 1'b0;
        if (grant_vld) begin
            ptr_d    = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + PW'(1);
            waddr_d  = addr_arr[grant_idx];
            wdata_d  = data_arr[grant_idx];
            reg_wr_d = (addr_arr[grant_idx] != '0);
        end
    end

    // Scoreboard next state: retiring write clears, reservation sets and wins.
    always_comb begin
        pending_d = pending_q;
        if (reg_wr_q) begin
            pending_d[waddr_q] = 1'b0;
        end
        if (bus.rsv_valid && (bus.rsv_addr != '0)) begin
            pending_d[bus.rsv_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pointer and registered write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            reg_wr_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            reg_wr_q <= reg_wr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Pending-write bitmask.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.pending   = pending_q;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file. It shares the file's single write port (reg_wr/waddr/wdata) between NUM_REQ write-back sources (ALU, load unit, mul/div) using round-robin arbitration. It also keeps a pending-write bitmask that the issue stage reserves at dispatch and that clears after the write retires. It sits between the execute/memory units and the register file, and feeds pending to hazard detection.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..8)
- AW, 5, register address width
- DW, 32, data width
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  requester i has a write pending
- req_addr  input  NUM_REQ*AW  destination register of requester i, slice [i*AW +: AW]
- req_data  input  NUM_REQ*DW  write data of requester i, slice [i*DW +: DW]
- req_ready  output  NUM_REQ  one-hot grant; requester i's write is accepted on an edge where req_valid[i] && req_ready[i]
- rsv_valid  input  1  issue stage reserves rsv_addr this cycle
- rsv_addr  input  AW  register being reserved
- pending  output  2**AW  bit r = 1 while register r has an outstanding write
- reg_wr  output  1  register-file write enable (registered)
- waddr  output  AW  register-file write address (registered)
- wdata  output  DW  register-file write data (registered)

## Operation
- Arbitration is combinational. Scan from pointer ptr upward, modulo NUM_REQ. The first i with req_valid[i] gets req_ready[i]=1; all other ready bits are 0. If no valid is asserted, req_ready=0.
- req_ready depends only on req_valid and ptr, never on addr or data.
- On an accepting edge for requester g:
  - ptr <= (g+1) mod NUM_REQ.
  - waddr <= req_addr[g], wdata <= req_data[g].
  - reg_wr <= (req_addr[g] != 0).
- On an edge with no acceptance: reg_wr <= 0, and ptr, waddr and wdata hold.
- x0 writes are accepted (ready asserts, ptr advances) but produce no reg_wr and touch no pending bit.
- Scoreboard, evaluated per edge:
  - set: rsv_valid && rsv_addr != 0 sets pending[rsv_addr].
  - clear: a retiring write, i.e. reg_wr==1 in the cycle ending at this edge, clears pending[waddr].
  - Set and clear on the same register in the same edge: the set wins and the bit stays 1 (a new writer has been issued).
- pending[0] is constantly 0.
- A write to a register whose pending bit is 0 is legal. It is written normally, and clearing an already-0 bit is a no-op.
- Requesters must hold valid, addr and data stable until accepted. The arbiter is not required to tolerate valid being dropped before acceptance.

## Timing
- Reset, synchronous, on a posedge with rst=1: ptr=0, reg_wr=0, waddr=0, wdata=0, pending=0.
- While rst=1, req_ready is forced to 0 and no request is accepted. A request valid during reset is first considered on the first edge after rst deasserts.
- rst asserted mid-operation discards an in-flight write: reg_wr is 0 in the cycle after the reset edge, and pending is cleared.
- Latency for a request accepted at edge E0:
  - reg_wr/waddr/wdata are valid throughout the cycle E0..E1, so the register file's negedge write lands mid-cycle.
  - pending[waddr] clears at E1, so any read after E1 sees the new value.
- Throughput is one accepted write per cycle, sustained. With all NUM_REQ requesters valid continuously, each is granted exactly once every NUM_REQ cycles.
- Reservation latency: pending[r] reads 1 from the cycle after the rsv edge.

## Test plan
- Reset: drive rst=1 for 2 cycles with req_valid=3'b111 -> req_ready=0, reg_wr=0, pending=0. First post-reset grant goes to requester 0.
- Single write: reserve r5, then requester 1 writes addr 5, data 0xDEADBEEF:
  - pending[5]=1 from the cycle after the reserve.
  - Cycle after acceptance: reg_wr=1, waddr=5, wdata=0xDEADBEEF.
  - pending[5]=0 one edge later.
- Round-robin: hold all three valid with addrs 1, 2, 3 for 6 cycles -> grant order 0,1,2,0,1,2 and reg_wr high every cycle with waddr 1,2,3,1,2,3.
- x0 drop: requester 2 writes addr 0, data 0x1234 -> ready asserts, ptr advances to 0, reg_wr stays 0, pending unchanged.
- Set/clear collision: write to r7 retiring on the same edge that rsv_valid reserves r7 -> pending[7]=1 after that edge. A later write to r7 clears it.
- Reset mid-flight: accept a write to r9 with pending[9]=1, then assert rst on the next edge -> reg_wr=0 after that edge, pending[9]=0.
